// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift register and its serial deserializer:
// mode-select encoding and the deserializer state type.
package shift_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_CLR  = 2'b11;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

endpackage

// File: rtl/deser_out_reg.sv
// One-deep output register for the deserializer: valid/ready handshake, sticky overrun
// on dropped words, and parity-error capture alongside the stored word.
module deser_out_reg #(
    parameter int unsigned DATA_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] word_i,
    input  logic              par_err_i,
    input  logic              ovr_clr_i,
    input  logic              ready_i,
    output logic [DATA_W-1:0] dout_o,
    output logic              valid_o,
    output logic              overrun_o,
    output logic              par_err_o
);

    logic [DATA_W-1:0] dout_q, dout_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;
    logic              par_err_q, par_err_d;
    logic              fire;

    always_comb begin
        dout_d    = dout_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        par_err_d = par_err_q;
        fire      = valid_q & ready_i;

        if (load_i) begin
            // A word still waiting and not taken this cycle wins; the new one is dropped.
            if (valid_q && !ready_i) begin
                overrun_d = 1'b1;
            end else begin
                dout_d    = word_i;
                valid_d   = 1'b1;
                par_err_d = par_err_i;
            end
        end else if (fire) begin
            valid_d = 1'b0;
        end

        if (ovr_clr_i) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dout_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            par_err_q <= par_err_d;
        end
    end

    assign dout_o    = dout_q;
    assign valid_o   = valid_q;
    assign overrun_o = overrun_q;
    assign par_err_o = par_err_q;

endmodule

// File: rtl/shift_deserializer.sv
// Serial-to-parallel receiver for the universal shift register's output (LSB- or MSB-first).
// Optional macro PARITY_CHK_EN appends one even-parity bit per frame and reports parity_err.
module shift_deserializer
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH_LEN = 2,
    parameter int unsigned DATA_W    = 4,
    localparam int unsigned CntW     = $clog2(DATA_W + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sin,
    input  logic                 sin_valid,
    input  logic [WIDTH_LEN-1:0] sel,
    output logic [DATA_W-1:0]    dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic [CntW-1:0]      bit_cnt,
    output logic                 overrun,
    output logic                 parity_err
);

`ifdef PARITY_CHK_EN
    localparam int unsigned FrameLen = DATA_W + 1;
`else
    localparam int unsigned FrameLen = DATA_W;
`endif

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic              dir_q, dir_d;

    logic              accept, clear, dir_now, complete, word_par_err;
    logic [DATA_W-1:0] shifted, word;

    always_comb begin
        accept  = sin_valid && (sel == WIDTH_LEN'(MODE_SHR) || sel == WIDTH_LEN'(MODE_SHL));
        clear   = (sel == WIDTH_LEN'(MODE_CLR));
        // Direction is taken from sel only on the first bit of a word (dir 1 = MSB-first).
        dir_now = (state_q == IDLE) ? (sel == WIDTH_LEN'(MODE_SHL)) : dir_q;
        shifted = dir_now ? {shreg_q[DATA_W-2:0], sin} : {sin, shreg_q[DATA_W-1:1]};

        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        state_d   = state_q;
        dir_d     = dir_q;
        complete  = 1'b0;

        if (clear) begin
            shreg_d   = '0;
            bit_cnt_d = '0;
            state_d   = IDLE;
        end else if (accept) begin
            dir_d = dir_now;
            // The trailing parity bit, when present, never enters the data register.
            if (bit_cnt_q < CntW'(DATA_W)) begin
                shreg_d = shifted;
            end
            if (bit_cnt_q == CntW'(FrameLen - 1)) begin
                complete  = 1'b1;
                bit_cnt_d = '0;
                state_d   = IDLE;
            end else begin
                bit_cnt_d = bit_cnt_q + CntW'(1);
                state_d   = SHIFT;
            end
        end

`ifdef PARITY_CHK_EN
        word         = shreg_q;
        word_par_err = (^shreg_q) ^ sin;
`else
        word         = shifted;
        word_par_err = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            dir_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            dir_q     <= dir_d;
        end
    end

    deser_out_reg #(
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clk_i     (clk),
        .rst_i     (rst),
        .load_i    (complete),
        .word_i    (word),
        .par_err_i (word_par_err),
        .ovr_clr_i (clear),
        .ready_i   (dout_ready),
        .dout_o    (dout),
        .valid_o   (dout_valid),
        .overrun_o (overrun),
        .par_err_o (parity_err)
    );

    assign bit_cnt = bit_cnt_q;

endmodule

// File: tb/tb_shift_deserializer.sv
// Self-checking bench for shift_deserializer: directed scenarios plus randomized traffic
// compared against a bit-queue reference model.
module tb_shift_deserializer;

    localparam int DATA_W = 4;
    localparam int CntW   = $clog2(DATA_W + 1);
`ifdef PARITY_CHK_EN
    localparam int FRAME = DATA_W + 1;
`else
    localparam int FRAME = DATA_W;
`endif

    logic              clk;
    logic              rst;
    logic              sin;
    logic              sin_valid;
    logic [1:0]        sel;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;
    logic [CntW-1:0]   bit_cnt;
    logic              overrun;
    logic              parity_err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int                m_bits[$];
    bit                m_dir;
    logic [DATA_W-1:0] m_dout;
    bit                m_valid;
    bit                m_ovr;
    bit                m_perr;

    shift_deserializer #(
        .WIDTH_LEN (2),
        .DATA_W    (DATA_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sin        (sin),
        .sin_valid  (sin_valid),
        .sel        (sel),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .bit_cnt    (bit_cnt),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_bits.delete();
        m_dir   = 1'b0;
        m_dout  = '0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_perr  = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model, then wait past the edge.
    task automatic step(input logic s, input logic sv, input logic [1:0] md, input logic rdy);
        logic [DATA_W-1:0] w;
        bit                par;
        bit                done;
        sin        = s;
        sin_valid  = sv;
        sel        = md;
        dout_ready = rdy;
        done       = 1'b0;
        w          = '0;
        par        = 1'b0;
        if (md == 2'b11) begin
            m_bits.delete();
            m_ovr = 1'b0;
        end else if (sv && (md == 2'b01 || md == 2'b10)) begin
            if (m_bits.size() == 0) m_dir = (md == 2'b10);
            m_bits.push_back(int'(s));
            if (m_bits.size() == FRAME) begin
                done = 1'b1;
                for (int i = 0; i < DATA_W; i++) begin
                    if (m_dir) w[DATA_W-1-i] = m_bits[i][0];
                    else       w[i]          = m_bits[i][0];
                end
                for (int i = 0; i < FRAME; i++) par = par ^ m_bits[i][0];
                m_bits.delete();
            end
        end
        if (done) begin
            if (m_valid && !rdy) begin
                m_ovr = 1'b1;
            end else begin
                m_dout  = w;
                m_valid = 1'b1;
`ifdef PARITY_CHK_EN
                m_perr  = par;
`else
                m_perr  = 1'b0;
`endif
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    // Send a word with b[0] first; ready is raised only on the final step of the frame.
    task automatic send_word(input logic [DATA_W-1:0] b, input logic [1:0] md, input logic rdy_last);
        for (int i = 0; i < DATA_W; i++) begin
            step(b[i], 1'b1, md, (i == FRAME - 1) ? rdy_last : 1'b0);
        end
`ifdef PARITY_CHK_EN
        step(^b, 1'b1, md, rdy_last);
`endif
    endtask

    task automatic do_reset();
        sin        = 1'b0;
        sin_valid  = 1'b0;
        sel        = 2'b00;
        dout_ready = 1'b0;
        rst        = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({dout, dout_valid, bit_cnt, overrun, parity_err} !== '0) begin
            errors++;
            $display("FAIL reset_state: got dout=%h v=%b cnt=%0d ovr=%b perr=%b, need all 0",
                     dout, dout_valid, bit_cnt, overrun, parity_err);
        end
    endtask

    task automatic test_shr();
        do_reset();
        send_word(4'b1101, 2'b01, 1'b0);
        checks++;
        if (dout !== 4'b1101 || dout !== m_dout) begin
            errors++;
            $display("FAIL shr_word: got %b, need 1101", dout);
        end
        checks++;
        if (dout_valid !== 1'b1 || bit_cnt !== '0) begin
            errors++;
            $display("FAIL shr_flags: got valid=%b cnt=%0d, need 1/0", dout_valid, bit_cnt);
        end
    endtask

    task automatic test_shl_toggle();
        do_reset();
        step(1'b1, 1'b1, 2'b10, 1'b0);
        step(1'b0, 1'b1, 2'b10, 1'b0);
        step(1'b1, 1'b1, 2'b01, 1'b0);
        step(1'b1, 1'b1, 2'b01, 1'b0);
`ifdef PARITY_CHK_EN
        step(1'b1, 1'b1, 2'b01, 1'b0);
`endif
        checks++;
        if (dout !== 4'b1011 || dout_valid !== 1'b1) begin
            errors++;
            $display("FAIL shl_toggle: got dout=%b v=%b, need 1011/1", dout, dout_valid);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        send_word(4'hA, 2'b01, 1'b0);
        checks++;
        if (dout !== 4'hA || dout_valid !== 1'b1) begin
            errors++;
            $display("FAIL first_word: got dout=%h v=%b, need a/1", dout, dout_valid);
        end
        send_word(4'h5, 2'b01, 1'b0);
        checks++;
        if (dout !== 4'hA || overrun !== 1'b1 || bit_cnt !== '0) begin
            errors++;
            $display("FAIL overrun_set: got dout=%h ovr=%b cnt=%0d, need a/1/0", dout, overrun, bit_cnt);
        end
        step(1'b0, 1'b0, 2'b11, 1'b0);
        checks++;
        if (overrun !== 1'b0 || dout_valid !== 1'b1 || dout !== 4'hA) begin
            errors++;
            $display("FAIL overrun_clear: got ovr=%b v=%b dout=%h, need 0/1/a", overrun, dout_valid, dout);
        end
    endtask

    task automatic test_handshake_complete();
        // Continues from test_overrun with 4'hA still unread.
        send_word(4'h3, 2'b01, 1'b1);
        checks++;
        if (dout !== 4'h3 || dout_valid !== 1'b1 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle_handshake: got dout=%h v=%b ovr=%b, need 3/1/0",
                     dout, dout_valid, overrun);
        end
        step(1'b0, 1'b0, 2'b00, 1'b1);
        checks++;
        if (dout_valid !== 1'b0 || dout !== 4'h3) begin
            errors++;
            $display("FAIL drain: got v=%b dout=%h, need 0/3", dout_valid, dout);
        end
    endtask

    task automatic test_hold_and_reset();
        do_reset();
        send_word(4'hF, 2'b10, 1'b0);
        step(1'b1, 1'b1, 2'b01, 1'b0);
        step(1'b0, 1'b1, 2'b01, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 2'b00, 1'b0);
            checks++;
            if (bit_cnt !== CntW'(2)) begin
                errors++;
                $display("FAIL hold_cnt[%0d]: got %0d, need 2", i, bit_cnt);
            end
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({dout, dout_valid, bit_cnt, overrun, parity_err} !== '0) begin
            errors++;
            $display("FAIL async_reset: got dout=%h v=%b cnt=%0d ovr=%b perr=%b, need all 0",
                     dout, dout_valid, bit_cnt, overrun, parity_err);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

`ifdef PARITY_CHK_EN
    task automatic test_parity();
        do_reset();
        step(1'b1, 1'b1, 2'b01, 1'b0);
        step(1'b1, 1'b1, 2'b01, 1'b0);
        step(1'b0, 1'b1, 2'b01, 1'b0);
        step(1'b0, 1'b1, 2'b01, 1'b0);
        step(1'b1, 1'b1, 2'b01, 1'b0);
        checks++;
        if (parity_err !== 1'b1 || dout !== 4'b0011) begin
            errors++;
            $display("FAIL parity_bad: got perr=%b dout=%b, need 1/0011", parity_err, dout);
        end
        step(1'b0, 1'b0, 2'b00, 1'b1);
        step(1'b1, 1'b1, 2'b01, 1'b0);
        step(1'b1, 1'b1, 2'b01, 1'b0);
        step(1'b0, 1'b1, 2'b01, 1'b0);
        step(1'b0, 1'b1, 2'b01, 1'b0);
        step(1'b0, 1'b1, 2'b01, 1'b0);
        checks++;
        if (parity_err !== 1'b0 || dout !== 4'b0011 || dout_valid !== 1'b1) begin
            errors++;
            $display("FAIL parity_good: got perr=%b dout=%b v=%b, need 0/0011/1",
                     parity_err, dout, dout_valid);
        end
    endtask
`endif

    task automatic test_random();
        logic [1:0]      md;
        logic [CntW-1:0] exp_cnt;
        int              r;
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            r = int'($urandom_range(0, 31));
            if (r == 0)       md = 2'b11;
            else if (r < 4)   md = 2'b00;
            else if (r < 18)  md = 2'b01;
            else              md = 2'b10;
            step(1'($urandom), ($urandom_range(0, 3) != 0), md, ($urandom_range(0, 2) == 0));
            exp_cnt = CntW'(m_bits.size());
            checks++;
            if (dout !== m_dout || dout_valid !== m_valid || bit_cnt !== exp_cnt ||
                overrun !== m_ovr || parity_err !== m_perr) begin
                errors++;
                $display("FAIL random[%0d]: got dout=%h v=%b cnt=%0d ovr=%b perr=%b, need %h/%b/%0d/%b/%b",
                         n, dout, dout_valid, bit_cnt, overrun, parity_err,
                         m_dout, m_valid, exp_cnt, m_ovr, m_perr);
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        sin        = 1'b0;
        sin_valid  = 1'b0;
        sel        = 2'b00;
        dout_ready = 1'b0;
        model_reset();
        test_reset();
        test_shr();
        test_shl_toggle();
        test_overrun();
        test_handshake_complete();
        test_hold_and_reset();
`ifdef PARITY_CHK_EN
        test_parity();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
